fifo_sum_data_gen: RTL

Paced matrix stream source for the FIFO three-row sum controller. On a start pulse it emits one frame of (CNT_ROW_MAX+1) x (CNT_COL_MAX+1) bytes as single-cycle strobes spaced CNT_GAP_MAX+1 clocks apart. Its outputs drive the controller's pi_flag/pi_data inputs directly. A trailing drain period and a frame_done pulse let a testbench or upper-level sequencer chain frames safely.

---
 rtl/fifo_sum_data_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fifo_sum_data_gen.sv
// fifo_sum_data_gen: paced matrix stream source feeding the FIFO three-row sum controller.
// Emits one frame of (CNT_ROW_MAX+1) x (CNT_COL_MAX+1) bytes per start pulse, one strobe every
// CNT_GAP_MAX+1 clocks, then drains for CNT_GAP_MAX+1 clocks and pulses frame_done.
// Ports:
//   sys_clk    - system clock, rising edge
//   sys_rst_n  - asynchronous active-low reset
//   start      - frame request, only honoured while idle
//   hold       - freezes beat pacing while a frame is running
//   po_flag    - one-cycle data strobe
//   po_data    - beat data, held between strobes
//   busy       - high while a frame or its drain period is in progress
//   frame_done - one-cycle pulse when the drain period ends
module fifo_sum_data_gen #(
  parameter logic [7:0] CNT_COL_MAX = 8'd3,
  parameter logic [7:0] CNT_ROW_MAX = 8'd4,
  parameter logic [7:0] CNT_GAP_MAX = 8'd9,
  parameter logic [7:0] DATA_MAX    = 8'd99
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       hold,
  output logic       po_flag,
  output logic [7:0] po_data,
  output logic       busy,
  output logic       frame_done
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, TAIL = 2'd2} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_gap_q, cnt_gap_d;
  logic [7:0] cnt_col_q, cnt_col_d;
  logic [7:0] cnt_row_q, cnt_row_d;
  logic [7:0] cnt_tail_q, cnt_tail_d;
  logic [7:0] data_val_q, data_val_d;
  logic [7:0] po_data_q, po_data_d;
  logic       po_flag_q, po_flag_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  always_comb begin
    state_d      = state_q;
    cnt_gap_d    = cnt_gap_q;
    cnt_col_d    = cnt_col_q;
    cnt_row_d    = cnt_row_q;
    cnt_tail_d   = cnt_tail_q;
    data_val_d   = data_val_q;
    po_data_d    = po_data_q;
    po_flag_d    = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_gap_d = 8'd0;
          cnt_col_d = 8'd0;
          cnt_row_d = 8'd0;
        end
      end
      RUN: begin
        // hold freezes the pacing counter even at CNT_GAP_MAX, so a pending beat waits for hold=0
        if (!hold) begin
          if (cnt_gap_q == CNT_GAP_MAX) begin
            po_flag_d  = 1'b1;
            po_data_d  = data_val_q;
            cnt_gap_d  = 8'd0;
            data_val_d = (data_val_q == DATA_MAX) ? 8'd0 : data_val_q + 8'd1;
            if (cnt_col_q == CNT_COL_MAX) begin
              cnt_col_d = 8'd0;
              if (cnt_row_q == CNT_ROW_MAX) begin
                cnt_row_d  = 8'd0;
                cnt_tail_d = 8'd0;
                state_d    = TAIL;
              end else begin
                cnt_row_d = cnt_row_q + 8'd1;
              end
            end else begin
              cnt_col_d = cnt_col_q + 8'd1;
            end
          end else begin
            cnt_gap_d = cnt_gap_q + 8'd1;
          end
        end
      end
      TAIL: begin
        // drain period lets downstream pipelines flush before frame_done
        if (cnt_tail_q == CNT_GAP_MAX) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          cnt_tail_d = cnt_tail_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      cnt_gap_q    <= 8'd0;
      cnt_col_q    <= 8'd0;
      cnt_row_q    <= 8'd0;
      cnt_tail_q   <= 8'd0;
      data_val_q   <= 8'd0;
      po_data_q    <= 8'd0;
      po_flag_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_gap_q    <= cnt_gap_d;
      cnt_col_q    <= cnt_col_d;
      cnt_row_q    <= cnt_row_d;
      cnt_tail_q   <= cnt_tail_d;
      data_val_q   <= data_val_d;
      po_data_q    <= po_data_d;
      po_flag_q    <= po_flag_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign po_flag    = po_flag_q;
  assign po_data    = po_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
endmodule
